// File: rtl/booth_seq_accumulator.sv
// booth_seq_accumulator
//   Sequential radix-4 Booth multiplier back end. Captures a signed 16x16
//   operand pair and drives one Booth digit select per cycle to a shared
//   combinational partial-product stage. It accumulates each returned
//   partial product, with its +1 negate correction, at weight 4^j. The
//   signed 32-bit product is presented on a valid/ready output.
//   Optional build macro: BOOTH_ACC_EARLY_EXIT_EN. When it is defined, the
//   multiply finishes as soon as all remaining multiplier digits are zero.
module booth_seq_accumulator #(
  parameter int unsigned A_W    = 16,
  parameter int unsigned NDIG   = A_W / 2,
  parameter int unsigned PROD_W = 2 * A_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [A_W-1:0]    in_a,
  input  logic [A_W-1:0]    in_b,
  output logic              booth_b2,
  output logic              booth_b1,
  output logic              booth_b0,
  output logic [A_W-1:0]    booth_a,
  input  logic [A_W:0]      booth_p,
  input  logic              booth_neg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_prod
);

  localparam int unsigned J_W = $clog2(NDIG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [A_W-1:0]      a_q, a_d;
  logic [A_W-1:0]      b_q, b_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [J_W-1:0]      j_q, j_d;

  logic [A_W:0]        b_ext;
  logic [4:0]          shamt;
  logic [PROD_W-1:0]   pp_ext;
  logic [PROD_W-1:0]   acc_next;
  logic                last_digit;
  logic                finish;
`ifdef BOOTH_ACC_EARLY_EXIT_EN
  logic [A_W-1:0]      b_upper;
  logic                tail_zero;
`endif

  // Digit selection and weighted accumulation of the current partial product
  always_comb begin
    // A zero appended below b supplies b[-1] = 0 for the first digit
    b_ext      = {b_q, 1'b0};
    shamt      = {1'b0, j_q, 1'b0};
    booth_b2   = 1'b0;
    booth_b1   = 1'b0;
    booth_b0   = 1'b0;
    if (state_q == RUN) begin
      booth_b2 = b_ext[shamt + 5'd2];
      booth_b1 = b_ext[shamt + 5'd1];
      booth_b0 = b_ext[shamt];
    end
    pp_ext     = {{(PROD_W-A_W-1){booth_p[A_W]}}, booth_p};
    acc_next   = acc_q + (pp_ext << shamt) + (PROD_W'(booth_neg) << shamt);
    last_digit = (j_q == J_W'(NDIG - 1));
`ifdef BOOTH_ACC_EARLY_EXIT_EN
    // Remaining digits are all zero when b[15:2j+1] is pure sign extension
    b_upper    = A_W'($signed(b_q) >>> (shamt + 5'd1));
    tail_zero  = (b_upper == '0) || (b_upper == '1);
    finish     = last_digit || tail_zero;
`else
    finish     = last_digit;
`endif
  end

  // Control FSM: next state and datapath register updates
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    j_d     = j_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_next;
        j_d   = j_q + J_W'(1);
        if (finish) begin
          prod_d  = acc_next;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      j_q     <= j_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_prod  = prod_q;
  assign booth_a   = a_q;

endmodule

// File: tb/tb_booth_seq_accumulator.sv
// Testbench for booth_seq_accumulator. It includes a behavioural radix-4
// Booth partial-product stage, a directed vector table, multi-cycle corner
// sequences and a randomised run against a signed-multiply reference.
module tb_booth_seq_accumulator;

`ifdef BOOTH_ACC_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        booth_b2, booth_b1, booth_b0;
  logic [15:0] booth_a;
  logic [16:0] booth_p;
  logic        booth_neg;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_prod;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_seq_accumulator dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .booth_b2(booth_b2), .booth_b1(booth_b1), .booth_b0(booth_b0),
    .booth_a(booth_a), .booth_p(booth_p), .booth_neg(booth_neg),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod)
  );

  // Booth stage: P is +A/+2A, or its one's complement with neg=1 for -A/-2A
  always_comb begin
    booth_p   = '0;
    booth_neg = 1'b0;
    case ({booth_b2, booth_b1, booth_b0})
      3'b001, 3'b010: booth_p = {booth_a[15], booth_a};
      3'b011:         booth_p = {booth_a, 1'b0};
      3'b100: begin booth_p = ~{booth_a, 1'b0};        booth_neg = 1'b1; end
      3'b101, 3'b110: begin booth_p = ~{booth_a[15], booth_a}; booth_neg = 1'b1; end
      3'b111: begin booth_p = '1;                      booth_neg = 1'b1; end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
    int          lat_ee;
  } vec_t;

  vec_t vecs[11];

  // Single operation with out_ready held at 1; checks latency and result
  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input int lat);
    int cyc;
    @(negedge clk);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      cyc++;
    end while (!out_valid && cyc < 30);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_latency"}, 32'(cyc), 32'(lat));
    chk({nm, "_prod"}, out_prod, exp);
    @(posedge clk);
  endtask

  task automatic wait_valid(input string nm);
    int cyc = 0;
    while (!out_valid && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  localparam int NR = 1500;
  logic [31:0] exp_q[$];
  int rnd_cyc;
  bit rnd_done;

  initial begin
    vecs[0]  = '{16'd3,      16'd5,      32'd15,         3};
    vecs[1]  = '{16'h8000,   16'h8000,   32'h40000000,   9};
    vecs[2]  = '{16'h8000,   16'h7FFF,   32'hC0008000,   9};
    vecs[3]  = '{16'hFFFF,   16'hFFFF,   32'h00000001,   2};
    vecs[4]  = '{16'd1234,   16'd0,      32'h00000000,   2};
    vecs[5]  = '{16'd1234,   16'hFFFF,   32'hFFFFFB2E,   2};
    vecs[6]  = '{16'd7,      16'hFFF7,   32'hFFFFFFC1,   4};
    vecs[7]  = '{16'hFFFB,   16'd100,    32'hFFFFFE0C,   5};
    vecs[8]  = '{16'd12345,  16'hFEBF,   32'hFFC38887,   6};
    vecs[9]  = '{16'h7FFF,   16'h7FFF,   32'h3FFF0001,   9};
    vecs[10] = '{16'h8000,   16'd1,      32'hFFFF8000,   2};

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_prod", out_prod, 32'd0);
    chk("rst_booth", {13'd0, booth_b2, booth_b1, booth_b0, booth_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod,
             EE ? vecs[i].lat_ee : 9);

    // Backpressure: result held, extra in_valid ignored, exactly one accept afterwards
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 16'd3; in_b = 16'd5;
    @(posedge clk);
    @(negedge clk);
    in_a = 16'd11; in_b = 16'hFFFE;
    wait_valid("bp_first");
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_prod", out_prod, 32'd15);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_hs_valid", 32'(out_valid), 32'd0);
    chk("bp_after_hs_in_ready", 32'(in_ready), 32'd1);
    chk("bp_after_hs_prod", out_prod, 32'd15);
    @(negedge clk);
    chk("bp_accept_once", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_valid("bp_second");
    chk("bp_second_prod", out_prod, 32'hFFFFFFEA);
    @(negedge clk);
    chk("bp_idle_after", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp_no_dup", {30'd0, in_ready, out_valid}, 32'd2);

    // Reset pulse during digit 4
    in_valid = 1'b1; in_a = 16'd3; in_b = 16'h7FFF;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    chk("rst_mid_digit4_sel", {29'd0, booth_b2, booth_b1, booth_b0}, 32'd7);
    chk("rst_mid_booth_a", 32'(booth_a), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_booth_a_clr", 32'(booth_a), 32'd0);
    chk("rst_mid_prod_clr", out_prod, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 16'd7, 16'hFFF7, 32'hFFFFFFC1, EE ? 4 : 9);

    // Random operands with random in_valid and out_ready
    rnd_cyc = 0;
    rnd_done = 1'b0;
    fork
      begin : driver
        for (int k = 0; k < NR; k++) begin
          logic [15:0] ra, rb;
          bit took;
          ra = 16'($urandom);
          rb = 16'($urandom);
          if (k % 50 == 0) ra = 16'h8000;
          if (k % 70 == 0) rb = 16'h8000;
          took = 1'b0;
          while (!took && !rnd_done) begin
            @(negedge clk);
            in_a = ra; in_b = rb;
            in_valid = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
              exp_q.push_back(32'(int'($signed(ra)) * int'($signed(rb))));
              took = 1'b1;
            end
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin : monitor
        int got = 0;
        while (got < NR && rnd_cyc < 60000) begin
          @(negedge clk);
          rnd_cyc++;
          out_ready = ($urandom_range(0, 1) != 0);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL rnd_extra_result: got %h expected none", out_prod);
            end else begin
              chk("rnd_prod", out_prod, exp_q.pop_front());
            end
            got++;
          end
        end
        rnd_done = 1'b1;
        chk("rnd_result_count", 32'(got), 32'(NR));
      end
    join
    out_ready = 1'b1;
    chk("rnd_pending_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
